// File: rtl/axil_rd_watchdog_pkg.sv
// -----------------------------------------------------------------------------
// axil_rd_watchdog_pkg
//   Shared constants for the AXI4-lite read watchdog:
//     - AXI response codes used by the block (OKAY, SLVERR)
//     - 2-bit state encoding for the watchdog FSM
//     - default data word returned on synthesized error responses
// -----------------------------------------------------------------------------
package axil_rd_watchdog_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Legacy-compatible state constants (plain vectors, not an enum).
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_ORPHAN = 2'd2;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage : axil_rd_watchdog_pkg

// File: rtl/axil_rd_watchdog.sv
// -----------------------------------------------------------------------------
// axil_rd_watchdog
//   AXI4-lite read-channel watchdog sitting between a read clock-domain
//   crossing (upstream, s_axil_*) and the peripheral interconnect
//   (downstream, m_axil_*). One read is forwarded at a time. If the peripheral
//   has not returned R within TIMEOUT cycles of the upstream AR acceptance,
//   an SLVERR carrying ERR_DATA is returned upstream so the requester never
//   hangs; the late downstream response is later drained and dropped.
//   Reads arriving while the late response is still outstanding are answered
//   immediately with SLVERR and are not forwarded.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_axil_ar*          : upstream AR channel (from the crossing)
//   s_axil_r*           : upstream R channel (to the crossing)
//   m_axil_ar*          : downstream AR channel (to the peripheral)
//   m_axil_r*           : downstream R channel (from the peripheral)
//   timeout             : one-cycle pulse on each watchdog expiry
//   err_count           : saturating count of all synthesized SLVERR responses
// -----------------------------------------------------------------------------
module axil_rd_watchdog
    import axil_rd_watchdog_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 32,
    parameter int          TIMEOUT    = 1024,
    parameter logic [31:0] ERR_DATA   = ERR_DATA_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,

    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready,

    output logic [ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]            m_axil_arprot,
    output logic                  m_axil_arvalid,
    input  logic                  m_axil_arready,

    input  logic [DATA_WIDTH-1:0] m_axil_rdata,
    input  logic [1:0]            m_axil_rresp,
    input  logic                  m_axil_rvalid,
    output logic                  m_axil_rready,

    output logic                  timeout,
    output logic [15:0]           err_count
);

    // Timer must be able to hold TIMEOUT-1; one extra bit of headroom keeps
    // the increment on the expiry cycle from wrapping (the FSM leaves ACTIVE).
    localparam int                  TW         = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]       TIMER_LAST = TW'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [TW-1:0] timer;

    logic ar_fire;
    logic r_fire;
    logic fwd;        // accepted AR that is forwarded downstream
    logic pass;       // real downstream response returned upstream
    logic expire;     // watchdog expiry in ACTIVE
    logic fast_fail;  // AR accepted while a late response is outstanding

    // Upstream AR is only taken when the R slot is free, so a synthesized or
    // real response can always be loaded without overwriting a pending beat.
    assign s_axil_arready = ((state == ST_IDLE) || (state == ST_ORPHAN)) && !s_axil_rvalid;
    assign m_axil_rready  = (state == ST_ACTIVE) || (state == ST_ORPHAN);

    assign ar_fire   = s_axil_arvalid && s_axil_arready;
    assign r_fire    = m_axil_rvalid && m_axil_rready;

    assign fwd       = (state == ST_IDLE)   && ar_fire;
    assign pass      = (state == ST_ACTIVE) && r_fire;
    // A response arriving on the last timer cycle wins over the expiry.
    assign expire    = (state == ST_ACTIVE) && !r_fire && (timer == TIMER_LAST);
    assign fast_fail = (state == ST_ORPHAN) && ar_fire;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (ar_fire) state_nx = ST_ACTIVE;
            ST_ACTIVE: begin
                if (r_fire)       state_nx = ST_IDLE;
                else if (expire)  state_nx = ST_ORPHAN;
            end
            // Drain and fast-fail may coincide; the fast-fail is already
            // answered through the R registers, so IDLE is correct either way.
            ST_ORPHAN: if (r_fire) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= state_nx;
            if (fwd)
                timer <= '0;
            else if (state == ST_ACTIVE)
                timer <= timer + TW'(1);
        end
    end

    // Downstream AR: held with a stable address until accepted, in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_axil_araddr  <= '0;
            m_axil_arprot  <= '0;
            m_axil_arvalid <= 1'b0;
        end else begin
            if (fwd) begin
                m_axil_araddr  <= s_axil_araddr;
                m_axil_arprot  <= s_axil_arprot;
                m_axil_arvalid <= 1'b1;
            end else if (m_axil_arready) begin
                m_axil_arvalid <= 1'b0;
            end
        end
    end

    // Upstream R: loaded only while empty (guaranteed by s_axil_arready), so
    // clearing on rready and loading never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axil_rdata  <= '0;
            s_axil_rresp  <= '0;
            s_axil_rvalid <= 1'b0;
        end else begin
            if (pass) begin
                s_axil_rdata  <= m_axil_rdata;
                s_axil_rresp  <= m_axil_rresp;
                s_axil_rvalid <= 1'b1;
            end else if (expire || fast_fail) begin
                s_axil_rdata  <= ERR_WORD;
                s_axil_rresp  <= RESP_SLVERR;
                s_axil_rvalid <= 1'b1;
            end else if (s_axil_rvalid && s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout   <= 1'b0;
            err_count <= '0;
        end else begin
            timeout <= expire;
            if ((expire || fast_fail) && (err_count != 16'hFFFF))
                err_count <= err_count + 16'd1;
        end
    end

endmodule : axil_rd_watchdog

// File: tb/tb_axil_rd_watchdog.sv
// -----------------------------------------------------------------------------
// tb_axil_rd_watchdog
//   Directed bench for axil_rd_watchdog with TIMEOUT=8. Inputs are driven 1 ns
//   after the rising edge; outputs are sampled there too, away from the edge.
//   "Cycle k" below means the period after the k-th rising edge counted from
//   the edge that completed the upstream AR handshake (cycle 0).
// -----------------------------------------------------------------------------
module tb_axil_rd_watchdog;
    import axil_rd_watchdog_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [AW-1:0] s_axil_araddr;
    logic [2:0]    s_axil_arprot;
    logic          s_axil_arvalid;
    logic          s_axil_arready;
    logic [DW-1:0] s_axil_rdata;
    logic [1:0]    s_axil_rresp;
    logic          s_axil_rvalid;
    logic          s_axil_rready;
    logic [AW-1:0] m_axil_araddr;
    logic [2:0]    m_axil_arprot;
    logic          m_axil_arvalid;
    logic          m_axil_arready;
    logic [DW-1:0] m_axil_rdata;
    logic [1:0]    m_axil_rresp;
    logic          m_axil_rvalid;
    logic          m_axil_rready;
    logic          timeout;
    logic [15:0]   err_count;

    int total = 0;
    int bad   = 0;
    int to_pulses = 0;

    always #5 clk = ~clk;

    axil_rd_watchdog #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT   (TO),
        .ERR_DATA  (32'hDEADBEEF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axil_araddr (s_axil_araddr),
        .s_axil_arprot (s_axil_arprot),
        .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready),
        .s_axil_rdata  (s_axil_rdata),
        .s_axil_rresp  (s_axil_rresp),
        .s_axil_rvalid (s_axil_rvalid),
        .s_axil_rready (s_axil_rready),
        .m_axil_araddr (m_axil_araddr),
        .m_axil_arprot (m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid),
        .m_axil_arready(m_axil_arready),
        .m_axil_rdata  (m_axil_rdata),
        .m_axil_rresp  (m_axil_rresp),
        .m_axil_rvalid (m_axil_rvalid),
        .m_axil_rready (m_axil_rready),
        .timeout       (timeout),
        .err_count     (err_count)
    );

    // Counts cycles in which the timeout pulse is high.
    always @(posedge clk) if (timeout === 1'b1) to_pulses++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Upstream AR handshake; returns in cycle 1 with arvalid dropped.
    task automatic issue_ar(input logic [AW-1:0] addr, input logic [2:0] prot);
        s_axil_araddr  = addr;
        s_axil_arprot  = prot;
        s_axil_arvalid = 1'b1;
        check("ar_ready", s_axil_arready, 1'b1);
        tick();
        s_axil_arvalid = 1'b0;
    endtask

    task automatic accept_r();
        s_axil_rready = 1'b1;
        tick();
        s_axil_rready = 1'b0;
        check("r_cleared", s_axil_rvalid, 1'b0);
    endtask

    // Full read with a peripheral that accepts AR in cycle 1 and answers in
    // cycle 2; upstream sees the data in cycle 3.
    task automatic normal_read(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        issue_ar(addr, 3'b010);
        check({tag, "_m_arvalid"}, m_axil_arvalid, 1'b1);
        check({tag, "_m_araddr"},  m_axil_araddr, addr);
        check({tag, "_m_arprot"},  m_axil_arprot, 3'b010);
        check({tag, "_ar_blocked"}, s_axil_arready, 1'b0);
        m_axil_arready = 1'b1;
        tick();
        m_axil_arready = 1'b0;
        check({tag, "_m_arvalid_drop"}, m_axil_arvalid, 1'b0);
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = data;
        m_axil_rresp  = RESP_OKAY;
        tick();
        m_axil_rvalid = 1'b0;
        check({tag, "_rvalid"}, s_axil_rvalid, 1'b1);
        check({tag, "_rdata"},  s_axil_rdata, data);
        check({tag, "_rresp"},  s_axil_rresp, RESP_OKAY);
        check({tag, "_no_to"},  timeout, 1'b0);
        accept_r();
    endtask

    // Wait from cycle 1 to cycle 9 with a silent peripheral, checking that no
    // response appears early, then check the synthesized error in cycle 9.
    task automatic wait_expiry(input string tag, input logic [15:0] exp_err);
        for (int c = 1; c < TO + 1; c++) begin
            check({tag, "_no_early_rvalid"}, s_axil_rvalid, 1'b0);
            check({tag, "_m_arvalid_held"},  m_axil_arvalid, 1'b1);
            tick();
        end
        check({tag, "_err_rvalid"}, s_axil_rvalid, 1'b1);
        check({tag, "_err_rresp"},  s_axil_rresp, RESP_SLVERR);
        check({tag, "_err_rdata"},  s_axil_rdata, 32'hDEADBEEF);
        check({tag, "_timeout"},    timeout, 1'b1);
        check({tag, "_err_count"},  err_count, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst_n          = 1'b0;
        s_axil_araddr  = '0;
        s_axil_arprot  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        m_axil_arready = 1'b0;
        m_axil_rdata   = '0;
        m_axil_rresp   = '0;
        m_axil_rvalid  = 1'b0;

        // ---- reset state ----
        tick(); tick();
        check("rst_s_rvalid",  s_axil_rvalid, 1'b0);
        check("rst_m_arvalid", m_axil_arvalid, 1'b0);
        check("rst_m_araddr",  m_axil_araddr, 32'h0);
        check("rst_s_rdata",   s_axil_rdata, 32'h0);
        check("rst_timeout",   timeout, 1'b0);
        check("rst_err_count", err_count, 16'h0);
        rst_n = 1'b1;
        tick();
        check("rst_arready", s_axil_arready, 1'b1);
        check("rst_rready",  m_axil_rready, 1'b0);

        // ---- normal read ----
        normal_read("norm", 32'h0000_1000, 32'h1234_5678);
        check("norm_err_count", err_count, 16'h0);
        check("norm_to_pulses", to_pulses, 0);

        // ---- silent peripheral: expiry at cycle 9 ----
        issue_ar(32'h0000_2000, 3'b001);
        wait_expiry("exp", 16'd1);
        check("exp_m_araddr_stable", m_axil_araddr, 32'h0000_2000);
        check("exp_ar_blocked", s_axil_arready, 1'b0);
        tick();  // cycle 10
        check("exp_timeout_one_cycle", timeout, 1'b0);
        check("exp_r_held", s_axil_rvalid, 1'b1);
        accept_r();  // cycle 11, ORPHAN
        check("orph_rready", m_axil_rready, 1'b1);
        check("orph_m_arvalid_still", m_axil_arvalid, 1'b1);
        m_axil_arready = 1'b1;
        tick();  // cycle 12
        m_axil_arready = 1'b0;
        check("orph_m_arvalid_drop", m_axil_arvalid, 1'b0);

        // ---- three fast-failed reads while ORPHAN (cycles 12..17) ----
        for (int k = 0; k < 3; k++) begin
            issue_ar(32'h0000_3000 + 32'(k * 4), 3'b000);
            check("ff_rvalid",    s_axil_rvalid, 1'b1);
            check("ff_rresp",     s_axil_rresp, RESP_SLVERR);
            check("ff_rdata",     s_axil_rdata, 32'hDEADBEEF);
            check("ff_no_timeout", timeout, 1'b0);
            check("ff_no_fwd",    m_axil_arvalid, 1'b0);
            accept_r();
        end
        check("ff_err_count", err_count, 16'd4);
        check("ff_to_pulses", to_pulses, 1);

        // ---- late response at cycle 20 is drained silently ----
        tick(); tick();  // cycle 20
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = 32'hAAAA_5555;
        m_axil_rresp  = RESP_OKAY;
        tick();
        m_axil_rvalid = 1'b0;
        check("drain_no_rbeat", s_axil_rvalid, 1'b0);
        check("drain_idle_rready", m_axil_rready, 1'b0);
        tick();
        check("drain_still_no_rbeat", s_axil_rvalid, 1'b0);
        normal_read("post_drain", 32'h0000_4000, 32'h0BAD_F00D);
        check("post_drain_err", err_count, 16'd4);

        // ---- R handshake in the expiry cycle (cycle 8) wins ----
        issue_ar(32'h0000_5000, 3'b000);
        m_axil_arready = 1'b1;
        tick();  // cycle 2
        m_axil_arready = 1'b0;
        for (int c = 2; c < TO; c++) tick();  // cycle 8
        check("race_no_rvalid_yet", s_axil_rvalid, 1'b0);
        m_axil_rvalid = 1'b1;
        m_axil_rdata  = 32'hCAFE_F00D;
        m_axil_rresp  = RESP_OKAY;
        tick();  // cycle 9
        m_axil_rvalid = 1'b0;
        check("race_rvalid", s_axil_rvalid, 1'b1);
        check("race_rdata",  s_axil_rdata, 32'hCAFE_F00D);
        check("race_rresp",  s_axil_rresp, RESP_OKAY);
        check("race_no_timeout", timeout, 1'b0);
        check("race_err_count", err_count, 16'd4);
        // Backpressure: outputs stay stable while rready is low.
        for (int c = 0; c < 5; c++) begin
            tick();
            check("stall_rvalid", s_axil_rvalid, 1'b1);
            check("stall_rdata",  s_axil_rdata, 32'hCAFE_F00D);
            check("stall_rresp",  s_axil_rresp, RESP_OKAY);
            check("stall_no_timeout", timeout, 1'b0);
        end
        accept_r();
        check("race_idle", s_axil_arready, 1'b1);
        check("race_to_pulses", to_pulses, 1);

        // ---- reset during ACTIVE ----
        issue_ar(32'h0000_6000, 3'b000);
        tick(); tick();
        check("ract_pre_arvalid", m_axil_arvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("ract_m_arvalid", m_axil_arvalid, 1'b0);
        check("ract_s_rvalid",  s_axil_rvalid, 1'b0);
        check("ract_err_count", err_count, 16'h0);
        check("ract_rready",    m_axil_rready, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        normal_read("ract_after", 32'h0000_7000, 32'h5A5A_A5A5);

        // ---- reset during ORPHAN (in the expiry cycle) ----
        issue_ar(32'h0000_8000, 3'b000);
        wait_expiry("rorph", 16'd1);
        rst_n = 1'b0;
        #1;
        check("rorph_s_rvalid",  s_axil_rvalid, 1'b0);
        check("rorph_m_arvalid", m_axil_arvalid, 1'b0);
        check("rorph_timeout",   timeout, 1'b0);
        check("rorph_err_count", err_count, 16'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("rorph_arready", s_axil_arready, 1'b1);
        normal_read("rorph_after", 32'h0000_9000, 32'h1357_9BDF);
        check("final_err_count", err_count, 16'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_axil_rd_watchdog
